// File: rtl/mux2_en_checked_if.sv
// Bus bundle for mux2_en_checked: data/select/enable/clear in, both registered
// mux results, the equivalence flags and the transition counter out.
interface mux2_en_checked_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic             e;
    logic             clr;
    logic [WIDTH-1:0] w_struct;
    logic [WIDTH-1:0] w_assign;
    logic             mismatch;
    logic             mismatch_sticky;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output a, b, s, e, clr,
        input  w_struct, w_assign, mismatch, mismatch_sticky, toggle_cnt
    );

    modport slave (
        input  a, b, s, e, clr,
        output w_struct, w_assign, mismatch, mismatch_sticky, toggle_cnt
    );
endinterface

// File: rtl/mux2_en_checked.sv
// Registered 2:1 mux with enable, built twice (gate network and dataflow) and
// cross-checked. Optional compare logic is enabled by macro MUX2_EQUIV_CHECK_EN.
module mux2_en_checked #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux2_en_checked_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s_n;
    logic [WIDTH-1:0] term_a;
    logic [WIDTH-1:0] term_b;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] y_a;

    logic [WIDTH-1:0] w_struct_q;
    logic [WIDTH-1:0] w_assign_q;
    logic [CNT_W-1:0] toggle_cnt_q;
    logic             toggle;

    // One shared inverter on the select feeds every bit slice of the gate path.
    not u_inv_s (s_n, bus.s);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and u_and_a (term_a[i], bus.a[i], s_n,   bus.e);
        and u_and_b (term_b[i], bus.b[i], bus.s, bus.e);
        or  u_or_y  (y_s[i],    term_a[i], term_b[i]);
    end

    assign y_a = bus.e ? (bus.s ? bus.b : bus.a) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_struct_q <= '0;
            w_assign_q <= '0;
        end else begin
            w_struct_q <= y_s;
            w_assign_q <= y_a;
        end
    end

    // A transition is counted in the cycle whose capture changes w_assign.
    assign toggle = (y_a != w_assign_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt_q <= '0;
        end else if (bus.clr) begin
            toggle_cnt_q <= '0;
        end else if (toggle && (toggle_cnt_q != CNT_MAX)) begin
            toggle_cnt_q <= toggle_cnt_q + 1'b1;
        end
    end

    assign bus.w_struct   = w_struct_q;
    assign bus.w_assign   = w_assign_q;
    assign bus.toggle_cnt = toggle_cnt_q;

`ifdef MUX2_EQUIV_CHECK_EN
    logic diff;
    logic mismatch_q;
    logic sticky_q;

    assign diff = |(y_s ^ y_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            mismatch_q <= diff;
            // clr beats a mismatch arriving in the same cycle.
            sticky_q   <= bus.clr ? 1'b0 : (sticky_q | diff);
        end
    end

    assign bus.mismatch        = mismatch_q;
    assign bus.mismatch_sticky = sticky_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && diff) begin
            $error("mux2_en_checked: path disagreement at %0t a=%h b=%h s=%b e=%b y_s=%h y_a=%h",
                   $time, bus.a, bus.b, bus.s, bus.e, y_s, y_a);
        end
    end
`endif
`else
    assign bus.mismatch        = 1'b0;
    assign bus.mismatch_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mux2_en_checked.sv
// Self-checking bench for mux2_en_checked: directed plan sequences, exhaustive
// and random sweeps, counter saturation/clear, and asynchronous reset.
module tb_mux2_en_checked;
    localparam int W = 8;
    localparam int C = 8;
    localparam int C_MAX = (1 << C) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux2_en_checked_if #(.WIDTH(W), .CNT_W(C)) bus ();

    mux2_en_checked #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_out;
    int           m_cnt;
    logic [W-1:0] exp_y;

    // Reference rule: disabled gives zero, otherwise s picks b over a.
    function automatic logic [W-1:0] ref_mux(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s, input logic e);
        if (!e)     return '0;
        else if (s) return b;
        else        return a;
    endfunction

    task automatic model_reset();
        m_out = '0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    // Apply one vector, advance the model, and return #1 after the capturing edge.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic e, input logic clr);
        logic [W-1:0] y;
        bus.a   = a;
        bus.b   = b;
        bus.s   = s;
        bus.e   = e;
        bus.clr = clr;
        y = ref_mux(a, b, s, e);
        exp_q.push_back(y);
        if (clr)                               m_cnt = 0;
        else if (y != m_out && m_cnt < C_MAX)  m_cnt = m_cnt + 1;
        m_out = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        bus.s   = 1'b0;
        bus.e   = 1'b0;
        bus.clr = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.w_struct !== '0 || bus.w_assign !== '0 || bus.mismatch !== 1'b0 ||
            bus.mismatch_sticky !== 1'b0 || bus.toggle_cnt !== '0) begin
            failures++;
            $display("FAIL reset_state: ws=%h wa=%h mm=%b st=%b cnt=%0d required all zero",
                     bus.w_struct, bus.w_assign, bus.mismatch, bus.mismatch_sticky, bus.toggle_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_directed();
        logic [3:0] codes [6] = '{4'b0111, 4'b1111, 4'b1101, 4'b1001, 4'b1011, 4'b1001};
        for (int i = 0; i < 6; i++) begin
            logic [3:0] c;
            c = codes[i];
            drive({W{c[3]}}, {W{c[2]}}, c[1], c[0], 1'b0);
            exp_y = exp_q.pop_front();
            checks++;
            if (bus.w_struct !== exp_y || bus.w_assign !== exp_y || bus.mismatch !== 1'b0 ||
                bus.toggle_cnt !== m_cnt[C-1:0]) begin
                failures++;
                $display("FAIL directed[%0d]: ws=%h wa=%h mm=%b cnt=%0d required y=%h mm=0 cnt=%0d",
                         i, bus.w_struct, bus.w_assign, bus.mismatch, bus.toggle_cnt, exp_y, m_cnt);
            end
            if (i == 0) begin
                checks++;
                if (bus.w_assign !== {W{1'b1}} || bus.toggle_cnt !== 8'd1) begin
                    failures++;
                    $display("FAIL first_capture: wa=%h cnt=%0d required ff and 1",
                             bus.w_assign, bus.toggle_cnt);
                end
            end
        end
        checks++;
        if (bus.toggle_cnt !== 8'd3) begin
            failures++;
            $display("FAIL directed_cnt: cnt=%0d required 3", bus.toggle_cnt);
        end
    endtask

    task automatic test_enable_low();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] c;
            c = i[2:0];
            drive({W{c[2]}}, {W{c[1]}}, c[0], 1'b0, 1'b0);
            exp_y = exp_q.pop_front();
            checks++;
            if (bus.w_struct !== '0 || bus.w_assign !== '0 || exp_y !== '0 ||
                bus.mismatch_sticky !== 1'b0 || bus.toggle_cnt !== m_cnt[C-1:0]) begin
                failures++;
                $display("FAIL enable_low[%0d]: ws=%h wa=%h st=%b cnt=%0d required 0 0 0 %0d",
                         i, bus.w_struct, bus.w_assign, bus.mismatch_sticky, bus.toggle_cnt, m_cnt);
            end
        end
    endtask

    task automatic test_sweep_random();
        for (int i = 0; i < 16 + 200; i++) begin
            logic [W-1:0] a, b;
            logic s, e;
            if (i < 16) begin
                a = {W{i[3]}}; b = {W{i[2]}}; s = i[1]; e = i[0];
            end else begin
                a = W'($urandom); b = W'($urandom);
                s = 1'($urandom_range(0, 1)); e = ($urandom_range(0, 3) != 0);
            end
            drive(a, b, s, e, 1'b0);
            exp_y = exp_q.pop_front();
            checks++;
            if (bus.w_struct !== exp_y || bus.w_assign !== exp_y || bus.mismatch !== 1'b0 ||
                bus.mismatch_sticky !== 1'b0 || bus.toggle_cnt !== m_cnt[C-1:0]) begin
                failures++;
                $display("FAIL sweep[%0d] a=%h b=%h s=%b e=%b: ws=%h wa=%h mm=%b st=%b cnt=%0d required y=%h cnt=%0d",
                         i, a, b, s, e, bus.w_struct, bus.w_assign, bus.mismatch,
                         bus.mismatch_sticky, bus.toggle_cnt, exp_y, m_cnt);
            end
        end
    endtask

    task automatic test_saturate_clear();
        for (int i = 0; i < 300; i++) begin
            drive(i[0] ? '0 : {W{1'b1}}, W'($urandom), 1'b0, 1'b1, 1'b0);
            exp_y = exp_q.pop_front();
            checks++;
            if (bus.w_assign !== exp_y || bus.toggle_cnt !== m_cnt[C-1:0]) begin
                failures++;
                $display("FAIL saturate[%0d]: wa=%h cnt=%0d required %h %0d",
                         i, bus.w_assign, bus.toggle_cnt, exp_y, m_cnt);
            end
        end
        checks++;
        if (bus.toggle_cnt !== 8'd255) begin
            failures++;
            $display("FAIL saturated_cnt: cnt=%0d required 255", bus.toggle_cnt);
        end
        // clr together with a transition: clear must win.
        drive(~m_out, '0, 1'b0, 1'b1, 1'b1);
        exp_y = exp_q.pop_front();
        checks++;
        if (bus.toggle_cnt !== 8'd0 || bus.w_assign !== exp_y || bus.mismatch_sticky !== 1'b0) begin
            failures++;
            $display("FAIL clr_priority: cnt=%0d wa=%h st=%b required 0 %h 0",
                     bus.toggle_cnt, bus.w_assign, bus.mismatch_sticky, exp_y);
        end
        drive(m_out, '0, 1'b0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        checks++;
        if (bus.toggle_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clr_hold: cnt=%0d required 0", bus.toggle_cnt);
        end
        drive(~m_out, '0, 1'b0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        checks++;
        if (bus.toggle_cnt !== 8'd1) begin
            failures++;
            $display("FAIL post_clr_count: cnt=%0d required 1", bus.toggle_cnt);
        end
    endtask

    task automatic test_async_reset();
        drive({W{1'b1}}, '0, 1'b0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.w_struct !== '0 || bus.w_assign !== '0 || bus.mismatch !== 1'b0 ||
            bus.mismatch_sticky !== 1'b0 || bus.toggle_cnt !== '0) begin
            failures++;
            $display("FAIL async_reset: ws=%h wa=%h mm=%b st=%b cnt=%0d required all zero",
                     bus.w_struct, bus.w_assign, bus.mismatch, bus.mismatch_sticky, bus.toggle_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.w_assign !== '0 || bus.toggle_cnt !== '0) begin
            failures++;
            $display("FAIL reset_held: wa=%h cnt=%0d required 0 0", bus.w_assign, bus.toggle_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive('0, 8'h5a, 1'b1, 1'b1, 1'b0);
        exp_y = exp_q.pop_front();
        checks++;
        if (bus.w_struct !== exp_y || bus.w_assign !== exp_y || bus.toggle_cnt !== 8'd1) begin
            failures++;
            $display("FAIL post_reset_capture: ws=%h wa=%h cnt=%0d required %h %h 1",
                     bus.w_struct, bus.w_assign, bus.toggle_cnt, exp_y, exp_y);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_enable_low();
        test_sweep_random();
        test_saturate_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
